// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the fabric configuration loader.
// The build macro CFG_LOADER_CHECKSUM_EN is consumed by cfg_loader_ctrl.
package cfg_loader_pkg;

    // Width of the bits_shifted counter.
    localparam int BITS_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_DONE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_READY  = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Number of chain chunks carried by one bitstream word.
    function automatic int chunks_per_word(input int word_w, input int cfg_w);
        return word_w / cfg_w;
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word buffer that breaks bitstream words into chain chunks, LSB first.
// Accepts a new word in the same cycle the last chunk leaves the buffer.
module cfg_word_serializer
    import cfg_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int CFG_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  last,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_ready,
    output logic                  word_take,
    output logic                  cfg_e,
    output logic [CFG_WIDTH-1:0]  cfg_i
);

    localparam int CHUNKS = chunks_per_word(WORD_WIDTH, CFG_WIDTH);
    localparam int CNT_W  = $clog2(CHUNKS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHUNKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WORD_WIDTH-1:0] buf_q;
    logic [CNT_W-1:0]      cnt_q;

    assign cfg_e      = active && (cnt_q != '0);
    assign cfg_i      = buf_q[CFG_WIDTH-1:0];
    assign word_ready = active && !last &&
                        ((cnt_q == '0) || ((cnt_q == CNT_ONE) && cfg_e));
    assign word_take  = word_ready && word_valid;

    // Load on accept, otherwise drain one chunk per enabled cycle.
    always_ff @(posedge clk) begin
        if (reset || !active || last) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else if (word_take) begin
            buf_q <= word_data;
            cnt_q <= CNT_FULL;
        end else if (cfg_e) begin
            buf_q <= buf_q >> CFG_WIDTH;
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/cfg_loader_ctrl.sv
// Configuration chain loader: serializes the bitstream, then settles user reset.
// Define CFG_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module cfg_loader_ctrl
    import cfg_loader_pkg::*;
#(
    parameter int WORD_WIDTH    = 16,
    parameter int CFG_WIDTH     = 1,
    parameter int TOTAL_BITS    = 115,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word_data,
    output logic                  word_ready,
    output logic                  cfg_e,
    output logic [CFG_WIDTH-1:0]  cfg_i,
    output logic                  user_reset,
    output logic                  busy,
    output logic                  ready,
    output logic                  error,
    output logic [BITS_W-1:0]     bits_shifted
);

    localparam logic [BITS_W-1:0] STEP  = BITS_W'(CFG_WIDTH);
    localparam logic [BITS_W-1:0] TOTAL = BITS_W'(TOTAL_BITS);
    localparam int SET_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(STABLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

    state_t              state_q, state_d;
    logic [BITS_W-1:0]   bits_q;
    logic [SET_W-1:0]    settle_q;
    logic                active, last, start_go;
    logic                ser_ready, word_take;
    logic                chk_take, chk_ok;

    assign active       = (state_q == ST_SHIFT);
    assign last         = cfg_e && ((bits_q + STEP) >= TOTAL);
    assign start_go     = start && ((state_q == ST_IDLE) || (state_q == ST_READY));
    assign bits_shifted = bits_q;

    cfg_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .CFG_WIDTH  (CFG_WIDTH)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .active     (active),
        .last       (last),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (ser_ready),
        .word_take  (word_take),
        .cfg_e      (cfg_e),
        .cfg_i      (cfg_i)
    );

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum_q;

    assign chk_take   = (state_q == ST_DONE) && word_valid;
    assign chk_ok     = (word_data == csum_q);
    assign word_ready = ser_ready || (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);

    // Running XOR of every word the serializer accepts in this load.
    always_ff @(posedge clk) begin
        if (reset || start_go) begin
            csum_q <= '0;
        end else if (word_take) begin
            csum_q <= csum_q ^ word_data;
        end
    end
`else
    assign chk_take   = 1'b1;
    assign chk_ok     = 1'b1;
    assign word_ready = ser_ready;
    assign error      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Count chain bits; cleared when a new load begins.
    always_ff @(posedge clk) begin
        if (reset || start_go) begin
            bits_q <= '0;
        end else if (cfg_e) begin
            bits_q <= bits_q + STEP;
        end
    end

    // Settle timer runs only while in SETTLE.
    always_ff @(posedge clk) begin
        if (reset || (state_q != ST_SETTLE)) begin
            settle_q <= '0;
        end else begin
            settle_q <= settle_q + SET_ONE;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d    = state_q;
        user_reset = 1'b1;
        busy       = 1'b0;
        ready      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy = 1'b1;
                if (chk_take) state_d = chk_ok ? ST_SETTLE : ST_ERROR;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_q == SET_LAST) state_d = ST_READY;
            end
            ST_READY: begin
                user_reset = 1'b0;
                ready      = 1'b1;
                if (start) state_d = ST_SHIFT;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cfg_loader_ctrl.sv
// Randomized bench for cfg_loader_ctrl (default and CFG_WIDTH=4 instances).
// Expected streams and timing come from the bitstream contents and load rules.
module tb_cfg_loader_ctrl;

    localparam int WW  = 16;
    localparam int CW  = 1;
    localparam int TB  = 115;
    localparam int SC  = 4;
    localparam int CW4 = 4;
    localparam int TB4 = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word_data = '0;
    logic        word_ready, cfg_e, user_reset, busy, ready, error;
    logic [0:0]  cfg_i;
    logic [31:0] bits_shifted;

    logic        start4 = 1'b0;
    logic        wv4 = 1'b0;
    logic [15:0] wd4 = '0;
    logic        wr4, cfg_e4, ur4, busy4, ready4, error4;
    logic [3:0]  cfg_i4;
    logic [31:0] bits4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cfg_loader_ctrl #(
        .WORD_WIDTH(WW), .CFG_WIDTH(CW), .TOTAL_BITS(TB), .STABLE_CYCLES(SC)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
        .cfg_e(cfg_e), .cfg_i(cfg_i), .user_reset(user_reset), .busy(busy),
        .ready(ready), .error(error), .bits_shifted(bits_shifted)
    );

    cfg_loader_ctrl #(
        .WORD_WIDTH(WW), .CFG_WIDTH(CW4), .TOTAL_BITS(TB4), .STABLE_CYCLES(SC)
    ) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .word_valid(wv4), .word_data(wd4), .word_ready(wr4),
        .cfg_e(cfg_e4), .cfg_i(cfg_i4), .user_reset(ur4), .busy(busy4),
        .ready(ready4), .error(error4), .bits_shifted(bits4)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({cfg_e, word_ready, user_reset, busy, ready, error} !== 6'b001000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 001000",
                     {cfg_e, word_ready, user_reset, busy, ready, error});
        end
        n_cmp++;
        if (bits_shifted !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_bits: got %0d want 0", bits_shifted);
        end
        n_cmp++;
        if ({cfg_e4, wr4, ur4, ready4} !== 4'b0010) begin
            n_bad++;
            $display("FAIL reset_flags4: got %b want 0010", {cfg_e4, wr4, ur4, ready4});
        end
        reset = 1'b0;
    endtask

    // One full load on the default instance; stall_at = accepted-word count
    // at which the source withholds data for stall_len offered cycles.
    task automatic run_load(input string tag, input int stall_at, input int stall_len,
                            input bit poke, input bit corrupt);
        logic [15:0] src [10];
        logic [15:0] x;
        int idx, n_e, first_e, last_e, rdy_cyc, stall_left, bit_err, cyc;
        int exp_en, exp_words, exp_idx;
        bit saw_err, r1_ready, r1_ur, r1_busy;
        logic [31:0] b1;
        exp_en    = (TB + CW - 1) / CW;
        exp_words = (exp_en * CW + WW - 1) / WW;
        exp_idx   = exp_words;
        x = '0;
        for (int i = 0; i < 10; i++) src[i] = 16'($urandom);
        for (int i = 0; i < exp_words; i++) x ^= src[i];
`ifdef CFG_LOADER_CHECKSUM_EN
        src[exp_words] = corrupt ? (x ^ 16'h0001) : x;
        exp_idx = exp_words + 1;
`endif
        idx = 0; n_e = 0; first_e = -1; last_e = -1; rdy_cyc = -1;
        bit_err = 0; saw_err = 0; stall_left = stall_len;
        r1_ready = 1'b1; r1_ur = 1'b0; r1_busy = 1'b0; b1 = 32'hffff_ffff;
        for (cyc = 0; cyc < 600 && rdy_cyc < 0 && !saw_err; cyc++) begin
            @(negedge clk);
            #1;
            start = (cyc == 0) ||
                    (poke && (cyc == 40 || (last_e >= 0 && cyc == last_e + 3)));
            if (stall_left > 0 && idx == stall_at && word_ready) begin
                word_valid = 1'b0;
                stall_left--;
            end else begin
                word_valid = 1'b1;
            end
            word_data = (idx < 10) ? src[idx] : 16'h0;
            #1;
            if (cyc == 1) begin
                r1_ready = ready; r1_ur = user_reset; r1_busy = busy; b1 = bits_shifted;
            end
            if (cfg_e) begin
                if (first_e < 0) first_e = cyc;
                last_e = cyc;
                if (n_e < 160 && cfg_i[0] !== src[n_e / WW][n_e % WW]) bit_err++;
                n_e++;
            end
            if (word_valid && word_ready) idx++;
            if (cyc > 0 && ready && rdy_cyc < 0) rdy_cyc = cyc;
            if (error) saw_err = 1'b1;
        end
        start = 1'b0;
        n_cmp++;
        if ({r1_ready, r1_ur, r1_busy} !== 3'b011) begin
            n_bad++;
            $display("FAIL %s start_flags: got %b want 011", tag, {r1_ready, r1_ur, r1_busy});
        end
        n_cmp++;
        if (b1 !== 32'd0) begin
            n_bad++;
            $display("FAIL %s bits_cleared: got %0d want 0", tag, b1);
        end
        n_cmp++;
        if (n_e != exp_en) begin
            n_bad++;
            $display("FAIL %s enables: got %0d want %0d", tag, n_e, exp_en);
        end
        n_cmp++;
        if (first_e != 2) begin
            n_bad++;
            $display("FAIL %s first_e: got %0d want 2", tag, first_e);
        end
        n_cmp++;
        if (last_e - first_e + 1 != exp_en + stall_len) begin
            n_bad++;
            $display("FAIL %s span: got %0d want %0d", tag,
                     last_e - first_e + 1, exp_en + stall_len);
        end
        n_cmp++;
        if (bit_err != 0) begin
            n_bad++;
            $display("FAIL %s bit_order: got %0d bad bits want 0", tag, bit_err);
        end
        n_cmp++;
        if (idx != exp_idx) begin
            n_bad++;
            $display("FAIL %s words: got %0d want %0d", tag, idx, exp_idx);
        end
        n_cmp++;
        if (bits_shifted !== 32'(exp_en * CW)) begin
            n_bad++;
            $display("FAIL %s bits_end: got %0d want %0d", tag, bits_shifted, exp_en * CW);
        end
        if (corrupt) begin
            n_cmp++;
            if (!saw_err || rdy_cyc >= 0) begin
                n_bad++;
                $display("FAIL %s csum_error: got err=%0d rdy=%0d want err=1 rdy=-1",
                         tag, saw_err, rdy_cyc);
            end
        end else begin
            n_cmp++;
            if (saw_err) begin
                n_bad++;
                $display("FAIL %s error: got 1 want 0", tag);
            end
            n_cmp++;
            if (rdy_cyc != last_e + SC + 2) begin
                n_bad++;
                $display("FAIL %s ready_at: got %0d want %0d", tag, rdy_cyc, last_e + SC + 2);
            end
            n_cmp++;
            if ({user_reset, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL %s ready_flags: got %b want 00", tag, {user_reset, busy});
            end
        end
    endtask

    task automatic test_wide_chunks;
        logic [15:0] src4 [4];
        logic [15:0] x;
        int idx, n_e, first_e, last_e, rdy_cyc, nib_err, exp_en, exp_words, exp_idx, k;
        exp_en    = (TB4 + CW4 - 1) / CW4;
        exp_words = (exp_en * CW4 + WW - 1) / WW;
        exp_idx   = exp_words;
        x = '0;
        for (int i = 0; i < 4; i++) src4[i] = 16'($urandom);
        for (int i = 0; i < exp_words; i++) x ^= src4[i];
`ifdef CFG_LOADER_CHECKSUM_EN
        src4[exp_words] = x;
        exp_idx = exp_words + 1;
`endif
        idx = 0; n_e = 0; first_e = -1; last_e = -1; rdy_cyc = -1; nib_err = 0;
        for (int cyc = 0; cyc < 100 && rdy_cyc < 0; cyc++) begin
            @(negedge clk);
            #1;
            start4 = (cyc == 0);
            wv4 = 1'b1;
            wd4 = (idx < 4) ? src4[idx] : 16'h0;
            #1;
            if (cfg_e4) begin
                if (first_e < 0) first_e = cyc;
                last_e = cyc;
                k = n_e * CW4;
                if (k < 64 && cfg_i4 !== src4[k / WW][(k % WW) +: 4]) nib_err++;
                n_e++;
            end
            if (wv4 && wr4) idx++;
            if (cyc > 0 && ready4 && rdy_cyc < 0) rdy_cyc = cyc;
        end
        start4 = 1'b0;
        n_cmp++;
        if (n_e != exp_en || last_e - first_e + 1 != exp_en) begin
            n_bad++;
            $display("FAIL wide enables: got %0d span %0d want %0d",
                     n_e, last_e - first_e + 1, exp_en);
        end
        n_cmp++;
        if (idx != exp_idx) begin
            n_bad++;
            $display("FAIL wide words: got %0d want %0d", idx, exp_idx);
        end
        n_cmp++;
        if (bits4 !== 32'(exp_en * CW4)) begin
            n_bad++;
            $display("FAIL wide bits_end: got %0d want %0d", bits4, exp_en * CW4);
        end
        n_cmp++;
        if (nib_err != 0) begin
            n_bad++;
            $display("FAIL wide chunk_order: got %0d bad chunks want 0", nib_err);
        end
        n_cmp++;
        if (rdy_cyc != last_e + SC + 2) begin
            n_bad++;
            $display("FAIL wide ready_at: got %0d want %0d", rdy_cyc, last_e + SC + 2);
        end
    endtask

    task automatic test_reset_mid_shift;
        int cyc;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        word_valid = 1'b1;
        word_data = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        #1;
        while (bits_shifted != 32'd50 && cyc < 300) begin
            @(negedge clk);
            #1;
            word_data = 16'($urandom);
            cyc++;
        end
        n_cmp++;
        if (bits_shifted !== 32'd50) begin
            n_bad++;
            $display("FAIL midreset reach50: got %0d want 50", bits_shifted);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({cfg_e, user_reset, busy, ready, word_ready} !== 5'b01000) begin
            n_bad++;
            $display("FAIL midreset flags: got %b want 01000",
                     {cfg_e, user_reset, busy, ready, word_ready});
        end
        n_cmp++;
        if (bits_shifted !== 32'd0) begin
            n_bad++;
            $display("FAIL midreset bits: got %0d want 0", bits_shifted);
        end
        reset = 1'b0;
        run_load("after_reset", -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_checksum;
`ifdef CFG_LOADER_CHECKSUM_EN
        run_load("csum_bad", -1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            start = (i == 3);
            n_cmp++;
            if ({error, ready, user_reset, cfg_e} !== 4'b1010) begin
                n_bad++;
                $display("FAIL csum_sticky: got %b want 1010",
                         {error, ready, user_reset, cfg_e});
            end
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL csum_clear: got %b want 0", error);
        end
        reset = 1'b0;
        run_load("csum_good", -1, 0, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        run_load("basic", -1, 0, 1'b0, 1'b0);
        run_load("stall", 3, 5, 1'b0, 1'b0);
        test_wide_chunks();
        test_reset_mid_shift();
        run_load("start_ignored", -1, 0, 1'b1, 1'b0);
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
